dmem_responder: RTL

Multi-cycle data-memory responder serving 32-bit big-endian word reads and writes from a request/acknowledge initiator, over a byte-organised store of 2**AW bytes. Each access is serialised into four byte cycles (byte at addr carries bits 31:24, addr+1 bits 23:16, addr+2 bits 15:8, addr+3 bits 7:0). It is the memory-side end of the processor's data-memory port, replacing the combinational byte array once the core moves to a stalling load/store unit.

---
 rtl/dmem_responder.sv | 119 +++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle big-endian word responder over a byte-organised store.
// Each accepted access is serialised into four byte cycles, then acked for one cycle.
module dmem_responder #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          busy,
  output logic          ack,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

  state_e        state_q;
  logic [1:0]    k_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [23:0]   rbuf_q;
  logic [31:0]   rdata_q;
  logic          busy_q;
  logic          ack_q;
  logic [7:0]    mem_q [DEPTH];

  logic [AW-1:0] byte_addr;
  logic [7:0]    wbyte;
  logic [7:0]    rbyte;
  logic          accept;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    byte_addr = addr_q + AW'(k_q);  // wraps naturally modulo the store depth
    rbyte     = mem_q[byte_addr];
    wbyte     = wdata_q[31:24];
    case (k_q)
      2'd0:    wbyte = wdata_q[31:24];
      2'd1:    wbyte = wdata_q[23:16];
      2'd2:    wbyte = wdata_q[15:8];
      default: wbyte = wdata_q[7:0];
    endcase
    accept = req && ((state_q == IDLE) || (state_q == DONE));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      // NOTE: the store is deliberately reset; software relies on it reading zero
      // after reset, which rules out mapping it onto a RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= XFER;
          end else begin
            state_q <= IDLE;
          end
        end
        XFER: begin
          if (we_q) begin
            mem_q[byte_addr] <= wbyte;
          end else begin
            case (k_q)
              2'd0:    rbuf_q[23:16] <= rbyte;
              2'd1:    rbuf_q[15:8]  <= rbyte;
              2'd2:    rbuf_q[7:0]   <= rbyte;
              default: ;
            endcase
          end
          if (k_q == 2'd3) begin
            // Last byte bypasses the shift buffer so rdata is valid with ack.
            if (!we_q) begin
              rdata_q <= {rbuf_q, rbyte};
            end
            busy_q  <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            k_q <= k_q + 2'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign ack   = ack_q;
  assign rdata = rdata_q;

endmodule
